// File: rtl/cdb_arbiter_pkg.sv
// Shared types for the common data bus arbiter and its consumers.
// e_functional_unit is the producer tag broadcast on the CDB; station index i
// maps to tag value i.
package cdb_arbiter_pkg;

    typedef enum logic [1:0] {
        FU_ALU = 2'd0,
        FU_MUL = 2'd1,
        FU_DIV = 2'd2,
        FU_LSU = 2'd3
    } e_functional_unit;

    localparam int CDB_TAG_W = $bits(e_functional_unit);

    // Station index to producer tag; the low tag bits of the index are the tag.
    function automatic e_functional_unit rs_index_to_fu(input int idx);
        logic [CDB_TAG_W-1:0] tag_s;
        tag_s = idx[CDB_TAG_W-1:0];
        return e_functional_unit'(tag_s);
    endfunction

endpackage

// File: rtl/cdb_arbiter_rr_priority_picker.sv
// Round-robin priority picker: finds the first set request bit searching
// upward from ptr, wrapping modulo N. Purely combinational so it can be
// shared with the issue unit. ptr is expected to be below N.
module rr_priority_picker
    import cdb_arbiter_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    localparam int               SUM_W = IDX_W + 1;
    localparam logic [SUM_W-1:0] N_L   = SUM_W'(N);

    logic [SUM_W-1:0] cand_s;
    logic             hit_s;
    logic [N-1:0]     gnt_s;
    logic [IDX_W-1:0] idx_s;

    // Walk the request vector starting at ptr and keep the first hit.
    always_comb begin
        gnt_s  = '0;
        idx_s  = '0;
        hit_s  = 1'b0;
        cand_s = '0;
        for (int off = 0; off < N; off++) begin
            cand_s = {1'b0, ptr} + SUM_W'(off);
            if (cand_s >= N_L) begin
                cand_s = cand_s - N_L;
            end else begin
                cand_s = cand_s;
            end
            if (!hit_s && req[cand_s[IDX_W-1:0]]) begin
                hit_s                     = 1'b1;
                idx_s                     = cand_s[IDX_W-1:0];
                gnt_s[cand_s[IDX_W-1:0]] = 1'b1;
            end else begin
                hit_s = hit_s;
            end
        end
    end

    assign gnt   = gnt_s;
    assign idx   = idx_s;
    assign valid = hit_s;

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter. Grants at most one ready reservation station per
// cycle (round-robin), pulses its retire strobe in the grant cycle and
// broadcasts its result and producer tag from a register in the next cycle.
// Optional macro CDB_ARB_PERF_EN adds grant / conflict / stall counters.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_RS     = 4
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [NUM_RS-1:0]                    ready_i,
    input  logic [NUM_RS-1:0][DATA_WIDTH-1:0]    result_i,
    input  logic                                 stall_i,
    output logic [NUM_RS-1:0]                    retire_o,
    output logic                                 bcast_en_o,
    output logic [DATA_WIDTH-1:0]                bcast_data_o,
    output logic [CDB_TAG_W-1:0]                 bcast_rs_o,
    output logic [$clog2(NUM_RS)-1:0]            grant_idx_o
`ifdef CDB_ARB_PERF_EN
    ,
    output logic [31:0]                          perf_grants_o,
    output logic [31:0]                          perf_conflict_o,
    output logic [31:0]                          perf_stall_o
`endif
);

    localparam int               IDX_W   = $clog2(NUM_RS);
    localparam logic [IDX_W-1:0] LAST_IX = IDX_W'(NUM_RS - 1);

    logic [IDX_W-1:0]      ptr_r;
    logic [NUM_RS-1:0]     pick_gnt_s;
    logic [IDX_W-1:0]      pick_idx_s;
    logic                  pick_valid_s;
    logic                  grant_s;
    logic [NUM_RS-1:0]     retire_s;
    logic [IDX_W-1:0]      ptr_next_s;
    logic                  bcast_en_r;
    logic [DATA_WIDTH-1:0] bcast_data_r;
    logic [CDB_TAG_W-1:0]  bcast_rs_r;

    rr_priority_picker #(
        .N     (NUM_RS),
        .IDX_W (IDX_W)
    ) u_picker (
        .req   (ready_i),
        .ptr   (ptr_r),
        .gnt   (pick_gnt_s),
        .idx   (pick_idx_s),
        .valid (pick_valid_s)
    );

    // Qualify the picker result: nothing is granted in reset or under stall.
    always_comb begin
        grant_s  = 1'b0;
        retire_s = '0;
        if (rst_n && !stall_i && pick_valid_s) begin
            grant_s  = 1'b1;
            retire_s = pick_gnt_s;
        end else begin
            grant_s  = 1'b0;
            retire_s = '0;
        end
    end

    // Pointer moves to the station just after the winner, wrapping.
    always_comb begin
        ptr_next_s = '0;
        if (pick_idx_s == LAST_IX) begin
            ptr_next_s = '0;
        end else begin
            ptr_next_s = pick_idx_s + IDX_W'(1);
        end
    end

    // Round-robin pointer and broadcast registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_r        <= '0;
            bcast_en_r   <= 1'b0;
            bcast_data_r <= '0;
            bcast_rs_r   <= '0;
        end else if (grant_s) begin
            ptr_r        <= ptr_next_s;
            bcast_en_r   <= 1'b1;
            bcast_data_r <= result_i[pick_idx_s];
            bcast_rs_r   <= rs_index_to_fu(int'(pick_idx_s));
        end else begin
            ptr_r        <= ptr_r;
            bcast_en_r   <= 1'b0;
            bcast_data_r <= bcast_data_r;
            bcast_rs_r   <= bcast_rs_r;
        end
    end

    assign retire_o     = retire_s;
    assign grant_idx_o  = pick_idx_s;
    assign bcast_en_o   = bcast_en_r;
    assign bcast_data_o = bcast_data_r;
    assign bcast_rs_o   = bcast_rs_r;

`ifdef CDB_ARB_PERF_EN
    logic [31:0] perf_grants_r;
    logic [31:0] perf_conflict_r;
    logic [31:0] perf_stall_r;
    logic        multi_ready_s;
    logic        any_ready_s;

    // Two or more bits set: clearing the lowest set bit leaves something.
    assign multi_ready_s = (ready_i & (ready_i - NUM_RS'(1))) != '0;
    assign any_ready_s   = ready_i != '0;

    // Free-running event counters, wrapping naturally at 2^32.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_grants_r   <= 32'd0;
            perf_conflict_r <= 32'd0;
            perf_stall_r    <= 32'd0;
        end else begin
            if (grant_s) begin
                perf_grants_r <= perf_grants_r + 32'd1;
            end else begin
                perf_grants_r <= perf_grants_r;
            end
            if (multi_ready_s && !stall_i) begin
                perf_conflict_r <= perf_conflict_r + 32'd1;
            end else begin
                perf_conflict_r <= perf_conflict_r;
            end
            if (stall_i && any_ready_s) begin
                perf_stall_r <= perf_stall_r + 32'd1;
            end else begin
                perf_stall_r <= perf_stall_r;
            end
        end
    end

    assign perf_grants_o   = perf_grants_r;
    assign perf_conflict_o = perf_conflict_r;
    assign perf_stall_o    = perf_stall_r;
`endif

endmodule
